uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between N_REQ byte producers (CPU UART peripheral, debug/status
//  dumper, ...). Grants round-robin, loads the byte, pulses tx_start, and tracks tx_busy until the frame
//  completes. Runs on the divided CPU clock, between the requesters and the UART TX serializer.
// PARAMETERS
//  N_REQ     2   number of requesters (>=2)
//  DATA_W    8   byte width
//  START_TO  4   cycles to wait for tx_busy after tx_start before declaring a timeout (>=1)
// PORTS
//  clk          in   1             system (divided) clock, rising edge
//  reset        in   1             asynchronous, active-low reset
//  req          in   N_REQ         req[i]=1: requester i has a byte pending; held until ack[i]
//  req_data     in   N_REQ*DATA_W  byte i at [i*DATA_W +: DATA_W]; stable while req[i]=1
//  req_last     in   N_REQ         last byte of packet (used only with UART_ARB_LOCK_EN)
//  ack          out  N_REQ         one-cycle pulse: byte of requester i captured
//  tx_data      out  DATA_W        byte presented to the serializer, held until the next grant
//  tx_start     out  1             one-cycle pulse requesting the serializer to start a frame
//  tx_busy      in   1             serializer busy (high for whole frame)
//  arb_busy     out  1             1 whenever the FSM is not in IDLE
//  grant_idx    out  clog2(N_REQ)  index of the last/current granted requester
//  err_timeout  out  1             sticky; set on a START_TO expiry, cleared only by reset
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, ack=0, tx_start=0, tx_data=0, arb_busy=0, grant_idx=0,
//   err_timeout=0, rr pointer=N_REQ-1 (requester 0 has top priority first), lock=0.
//  FSM states IDLE -> LOAD -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: if any req, pick first set req[i] scanning from (ptr+1) mod N_REQ upward with wrap; go LOAD.
//   No req: stay; all outputs idle.
//  LOAD (1 cycle): tx_data<=req_data[i], grant_idx<=i, ack[i]=1 for exactly this cycle, ptr<=i.
//  START (1 cycle): tx_start=1; tx_data stable. Then WAIT_BUSY with timeout counter cleared.
//  WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Counter reaching START_TO with tx_busy=0 -> err_timeout<=1, IDLE.
//   tx_busy already 1 on entry counts as seen (same-cycle handshake legal).
//  WAIT_DONE: tx_busy=0 -> IDLE. No timeout here (frame length set by baud rate).
//  Latency: req[i] rising in IDLE -> ack[i] 1 cycle later -> tx_start 2 cycles later.
//   Back-to-back bytes: next LOAD no earlier than the cycle after tx_busy falls.
//  Requests sampled only in IDLE; req changes in other states have no effect. req dropped before ack:
//   byte withdrawn, no ack. Simultaneous requests are never both acked in one cycle.
//  Fairness: with all N_REQ requesting continuously, grants cycle 0,1,..,N_REQ-1,0,...
//  Reset mid-frame: FSM returns to IDLE at once, tx_start forced 0; serializer frame is not aborted
//   by this block; first new grant waits in IDLE for a req as normal (tx_busy not checked in IDLE).
//  arb_busy = (state != IDLE), combinational from state register.
// CONFIGURATION
//  UART_ARB_LOCK_EN defined: when a byte with req_last[i]=0 is acked, lock<=1 and lock_idx<=i;
//   while locked, IDLE grants only requester lock_idx (others wait even if requesting); acking a byte
//   with req_last=1 clears lock. Keeps multi-byte packets contiguous on the line.
//  Not defined: req_last ignored, no lock registers, pure per-byte round-robin.
// TESTING
//  Reset: hold reset=0 with random req -> all outputs 0, no ack/tx_start; release -> IDLE.
//  Single byte: req[0]=1, data 0x55 -> ack[0] next cycle, tx_start after, tx_data=0x55;
//   model busy 1 cycle later for 10 cycles -> arb_busy falls the cycle after busy falls.
//  Contention: req=2'b11 held, data0=0xA0 data1=0xB1, re-raised after each ack -> line order A0,B1,A0,B1.
//  Timeout: tx_busy stuck 0 after tx_start -> after START_TO=4 cycles err_timeout=1, IDLE, next req served.
//  Reset mid-frame: assert reset during WAIT_DONE -> state IDLE, tx_start 0, err_timeout 0.
//  Lock (UART_ARB_LOCK_EN): req1 sends 0x01,0x02,0x03(last) while req0 pending -> 01,02,03 then req0's byte;
//   without macro same stimulus interleaves req0 after 0x01.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin arbiter sharing one UART TX serializer between
//                   N_REQ byte producers. Packet lock enabled by UART_ARB_LOCK_EN.
// Revision        : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = 8,
  parameter int START_TO = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           ack,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       arb_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_idx,
  output logic                       err_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    w_pick;
  logic             w_found;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] w_elig;
  logic             w_timeout;

`ifdef UART_ARB_LOCK_EN
  logic          r_lock;
  logic [IW-1:0] r_lock_idx;

  // A packet in flight reserves the line for its owner until its last byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (r_state == S_LOAD) begin
      r_lock     <= !req_last[grant_idx];
      r_lock_idx <= grant_idx;
    end
  end

  assign w_elig = r_lock ? (req & (N_REQ'(1) << r_lock_idx)) : req;
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_elig        = req;
`endif

  // Scan starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && w_elig[(int'(r_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_timeout = (r_state == S_WAIT_BUSY) && !tx_busy &&
                     (r_cnt == CW'(START_TO - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ack         = '0;
    tx_start    = 1'b0;
    arb_busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:      if (w_found) w_state_nxt = S_LOAD;
      S_LOAD: begin
        ack         = N_REQ'(1) << grant_idx;
        w_state_nxt = S_START;
      end
      S_START: begin
        tx_start    = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy)        w_state_nxt = S_WAIT_DONE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data     <= '0;
      grant_idx   <= '0;
      r_ptr       <= IW'(N_REQ - 1);
      r_cnt       <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) grant_idx <= w_pick;
      if (r_state == S_LOAD) begin
        tx_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
        r_ptr   <= grant_idx;
      end
      if (r_state == S_START)          r_cnt <= '0;
      else if (r_state == S_WAIT_BUSY) r_cnt <= r_cnt + CW'(1);
      if (w_timeout) err_timeout <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : directed self-checking bench with a simple serializer model.
// Revision           : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N_REQ    = 2;
  localparam int DATA_W   = 8;
  localparam int START_TO = 4;
  localparam int BUSY_LEN = 10;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    arb_busy;
  logic [0:0]              grant_idx;
  logic                    err_timeout;

  int checks   = 0;
  int failures = 0;

  logic [7:0] line_log[$];
  bit         stuck = 1'b0;
  bit         pend  = 1'b0;
  int         bcnt  = 0;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .START_TO(START_TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .arb_busy(arb_busy), .grant_idx(grant_idx), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Serializer model: busy rises the cycle after tx_start and stays high BUSY_LEN cycles.
  initial tx_busy = 1'b0;
  always @(negedge clk) begin
    if (tx_start) begin
      line_log.push_back(tx_data);
      if (!stuck) pend = 1'b1;
    end else if (pend) begin
      pend = 1'b0;
      bcnt = BUSY_LEN;
    end
    if (bcnt > 0) begin
      tx_busy = 1'b1;
      bcnt    = bcnt - 1;
    end else begin
      tx_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!arb_busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_one(input int idx, input logic [7:0] d, output bit ok);
    bit got_ack;
    got_ack = 1'b0;
    req[idx] = 1'b1;
    req_data[idx*DATA_W +: DATA_W] = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack[idx]) begin
        got_ack = 1'b1;
        break;
      end
    end
    req[idx] = 1'b0;
    wait_idle(ok);
    ok = ok && got_ack;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    bit         ok;
    int         n;
    int         base;
    int         n1;
    logic [7:0] exp_lock[4];

    // ---------------- reset with random request activity
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    req_last = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      req      = N_REQ'($urandom);
      req_data = (N_REQ*DATA_W)'($urandom);
      check("rst_ack", ack, 0);
      check("rst_start", tx_start, 0);
    end
    check("rst_data", tx_data, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_gidx", grant_idx, 0);
    check("rst_err", err_timeout, 0);
    req = '0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_rel_busy", arb_busy, 0);

    // ---------------- single byte, exact latency
    req[0] = 1'b1;
    req_data[7:0] = 8'h55;
    tick();
    check("single_ack", ack, 2'b01);
    check("single_nostart", tx_start, 0);
    req[0] = 1'b0;
    tick();
    check("single_start", tx_start, 1);
    check("single_data", tx_data, 8'h55);
    check("single_ack_pulse", ack, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (!arb_busy) break;
    end
    check("single_busy_len", n, 12);
    check("single_gidx", grant_idx, 0);

    // ---------------- contention, fresh pointer so requester 0 leads
    do_reset();
    base = line_log.size();
    req_data = {8'hB1, 8'hA0};
    req = 2'b11;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ack != 0) check("cont_onehot", $countones(ack), 1);
      if (tx_start) begin
        n++;
        if (n == 4) req = 2'b00;
      end
      if (n == 4 && !arb_busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("cont_done", ok, 1);
    check("cont_count", line_log.size() - base, 4);
    if (line_log.size() >= base + 4) begin
      check("cont_b0", line_log[base],   8'hA0);
      check("cont_b1", line_log[base+1], 8'hB1);
      check("cont_b2", line_log[base+2], 8'hA0);
      check("cont_b3", line_log[base+3], 8'hB1);
    end
    check("cont_gidx", grant_idx, 1);

    // ---------------- timeout: serializer never answers
    stuck = 1'b1;
    req[0] = 1'b1;
    req_data[7:0] = 8'h3C;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("to_started", ok, 1);
    req[0] = 1'b0;
    tick();
    tick();
    check("to_err_early", err_timeout, 0);
    check("to_busy_early", arb_busy, 1);
    for (int i = 0; i < 6; i++) tick();
    check("to_err_set", err_timeout, 1);
    check("to_idle", arb_busy, 0);
    stuck = 1'b0;
    base = line_log.size();
    send_one(1, 8'h77, ok);
    check("to_next_served", ok, 1);
    check("to_next_data", (line_log.size() > base) ? line_log[base] : 8'h00, 8'h77);
    check("to_err_sticky", err_timeout, 1);

    // ---------------- reset in the middle of a frame
    req[0] = 1'b1;
    req_data[7:0] = 8'h99;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start) break;
    end
    req[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_in_frame", arb_busy & tx_busy, 1);
    reset = 1'b0;
    #1;
    check("mid_idle", arb_busy, 0);
    check("mid_start", tx_start, 0);
    check("mid_err", err_timeout, 0);
    check("mid_ack", ack, 0);
    tick();
    reset = 1'b1;
    wait_idle(ok);
    check("mid_drain", ok, 1);

    // ---------------- packet lock (pointer primed so requester 1 wins first)
    send_one(0, 8'h11, ok);
    check("lock_prime", ok, 1);
    base = line_log.size();
    req_data = {8'h01, 8'hC0};
    req_last = 2'b00;
    req = 2'b11;
    n1 = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx_start) begin
        if (grant_idx == 1'b1) begin
          n1++;
          if (n1 == 1) req_data[15:8] = 8'h02;
          if (n1 == 2) begin
            req_data[15:8] = 8'h03;
            req_last[1]    = 1'b1;
          end
          if (n1 == 3) req[1] = 1'b0;
        end else begin
          req[0] = 1'b0;
        end
      end
      if (line_log.size() >= base + 4 && !arb_busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("lock_done", ok, 1);
`ifdef UART_ARB_LOCK_EN
    exp_lock = '{8'h01, 8'h02, 8'h03, 8'hC0};
`else
    exp_lock = '{8'h01, 8'hC0, 8'h02, 8'h03};
`endif
    if (line_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("lock_b%0d", i), line_log[base+i], exp_lock[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
